// File: rtl/rpn_cmd_scheduler_pkg.sv
// Shared definitions for the RPN command scheduler: opcodes, command entry
// layout and default queue depth. Opcode values follow the CPU button-bit
// numbering, so the pending vector bit index equals the opcode.
package rpn_cmd_scheduler_pkg;

  typedef enum logic [1:0] {
    RPN_OP_MLT  = 2'd0,
    RPN_OP_ADD  = 2'd1,
    RPN_OP_POP  = 2'd2,
    RPN_OP_PUSH = 2'd3
  } rpn_op_e;

  // Command entry is {op[1:0], data[7:0]}
  localparam int RPN_CMD_W         = 10;
  localparam int RPN_DEPTH_DEFAULT = 4;

  // Number of set bits in a 4-bit vector (used to count simultaneous drops)
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/rpn_cmd_fifo.sv
// Show-ahead command FIFO: the head entry is visible on rd_data whenever
// the FIFO is non-empty, and reads as zero when empty so no stale entry is
// ever presented. Reads on an empty FIFO are ignored; a write to a full
// FIFO is accepted only when a read happens on the same edge.
module rpn_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          rd_fire;
  logic          wr_fire;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr_en & (~full | rd_fire);
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  // Storage array: written only, never reset, so it can map to RAM
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_fire && !rd_fire)      count_reg <= count_reg + 1'b1;
      else if (rd_fire && !wr_fire) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/rpn_cmd_scheduler.sv
// RPN command scheduler: captures one-cycle button release pulses into a
// pending vector {push,pop,add,mult}, grants one pending source per cycle
// into a small show-ahead FIFO, and presents commands to the CPU over a
// valid/ready handshake. Events on a source that is already pending (and
// not being granted) are dropped and counted in a saturating counter.
// Optional build macro RR_ARB_EN selects round-robin arbitration; without
// it the arbiter is fixed priority PUSH > POP > ADD > MULT.
module rpn_cmd_scheduler
  import rpn_cmd_scheduler_pkg::*;
#(
  parameter int DEPTH = RPN_DEPTH_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ev_push,
  input  logic                       ev_pop,
  input  logic                       ev_add,
  input  logic                       ev_mult,
  input  logic [7:0]                 din,
  output logic                       cmd_valid,
  output logic [1:0]                 cmd_op,
  output logic [7:0]                 cmd_data,
  input  logic                       cmd_ready,
  output logic [3:0]                 pending,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       fifo_full,
  output logic [CNT_W-1:0]           drop_cnt
);

  logic [3:0]           pending_reg;
  logic [3:0]           pending_next;
  logic [7:0]           push_data_reg;
  logic [CNT_W-1:0]     drop_cnt_reg;
  logic [3:0]           ev_vec;
  logic [3:0]           grant_vec;
  logic [3:0]           drop_vec;
  logic                 grant_any;
  logic                 grant_fire;
  logic [1:0]           grant_idx;
  logic                 can_accept;
  logic                 rd_fire;
  logic                 fifo_empty;
  logic [RPN_CMD_W-1:0] wr_data;
  logic [RPN_CMD_W-1:0] head_data;
  logic [CNT_W:0]       drop_sum_wide;

  // Bit index equals opcode: push=3, pop=2, add=1, mult=0
  assign ev_vec = {ev_push, ev_pop, ev_add, ev_mult};

  // A full FIFO still accepts a write on the edge where the head is read
  assign cmd_valid  = ~fifo_empty;
  assign rd_fire    = cmd_valid & cmd_ready;
  assign can_accept = ~fifo_full | rd_fire;
  assign grant_fire = grant_any & can_accept;
  assign grant_vec  = grant_fire ? (4'b0001 << grant_idx) : 4'b0000;

`ifdef RR_ARB_EN
  logic [1:0] rr_ptr_reg;

  // Round-robin search in PUSH, POP, ADD, MULT order starting at the pointer
  always_comb begin
    logic [1:0] idx;
    grant_any = 1'b0;
    grant_idx = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_reg - 2'(k);
      if (!grant_any && pending_reg[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Pointer moves to the source following the one just granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= RPN_OP_PUSH;
    end else if (grant_fire) begin
      rr_ptr_reg <= grant_idx - 2'd1;
    end
  end
`else
  // Fixed priority: highest opcode (PUSH) wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!grant_any && pending_reg[k]) begin
        grant_any = 1'b1;
        grant_idx = 2'(k);
      end
    end
  end
`endif

  // Per-source capture: a new event re-arms the bit even on its grant cycle
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
      assign pending_next[gi] = ev_vec[gi] | (pending_reg[gi] & ~grant_vec[gi]);
      assign drop_vec[gi]     = ev_vec[gi] & pending_reg[gi] & ~grant_vec[gi];
    end
  endgenerate

  // The granted PUSH carries the data latched with its event, not din
  assign wr_data = {grant_idx,
                    (grant_idx == RPN_OP_PUSH) ? push_data_reg : 8'h00};

  assign drop_sum_wide = {1'b0, drop_cnt_reg} + (CNT_W+1)'(popcount4(drop_vec));

  // Pending vector, PUSH operand and saturating drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg   <= 4'b0000;
      push_data_reg <= 8'h00;
      drop_cnt_reg  <= '0;
    end else begin
      pending_reg <= pending_next;
      if (ev_push && (!pending_reg[RPN_OP_PUSH] || grant_vec[RPN_OP_PUSH])) begin
        push_data_reg <= din;
      end
      if (drop_sum_wide[CNT_W]) drop_cnt_reg <= '1;
      else                      drop_cnt_reg <= drop_sum_wide[CNT_W-1:0];
    end
  end

  rpn_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (RPN_CMD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (grant_fire),
    .wr_data (wr_data),
    .rd_en   (cmd_ready),
    .rd_data (head_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_op   = head_data[9:8];
  assign cmd_data = head_data[7:0];
  assign pending  = pending_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule
